bgd_mac_pipe: RTL and testbench



---
 rtl/bgd_mac_pipe.sv | 174 +++++++++++++++++
 tb/tb_bgd_mac_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bgd_mac_pipe.sv
// bgd_mac_pipe: pipelined signed multiply / multiply-accumulate unit.
// S1 registers the operands, S2 forms the exact product, S3 holds the
// accumulator, S4 scales/rounds/saturates, and any further stages are
// plain delay registers so total latency is NUM_STAGE ce-enabled edges.
//
// Valid semantics: din_valid qualifies din0/din1/acc_en/acc_clr on a
// ce-enabled edge; dout_valid qualifies dout/dout_sat. There is no
// backpressure: every ce-enabled edge accepts one slot, valid or bubble.
// Bubbles travel down the pipe and never touch the accumulator.
module bgd_mac_pipe #(
    parameter int A_WIDTH    = 15,
    parameter int B_WIDTH    = 15,
    parameter int P_WIDTH    = 15,
    parameter int ACC_GUARD  = 4,
    parameter int FRAC_SHIFT = 0,
    parameter int ROUND_EN   = 0,
    parameter int SAT_EN     = 0,
    parameter int NUM_STAGE  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      din_valid,
    input  logic signed [A_WIDTH-1:0] din0,
    input  logic signed [B_WIDTH-1:0] din1,
    input  logic                      acc_en,
    input  logic                      acc_clr,
    output logic                      dout_valid,
    output logic signed [P_WIDTH-1:0] dout,
    output logic                      dout_sat
);

    localparam int PROD_W = A_WIDTH + B_WIDTH;
    localparam int ACC_W  = PROD_W + ACC_GUARD;
    // Scaling is done two bits wider than both the accumulator and the
    // output so the rounding add cannot overflow and clip bounds always fit.
    localparam int EXT_W  = ((P_WIDTH > ACC_W) ? P_WIDTH : ACC_W) + 2;
    localparam int DLY_N  = NUM_STAGE - 3;

    localparam logic signed [EXT_W-1:0] RND =
        (ROUND_EN != 0 && FRAC_SHIFT > 0)
            ? (EXT_W'(1) <<< ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0))
            : '0;
    localparam logic signed [EXT_W-1:0] P_MAX =
        {{(EXT_W - P_WIDTH + 1){1'b0}}, {(P_WIDTH - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] P_MIN =
        {{(EXT_W - P_WIDTH + 1){1'b1}}, {(P_WIDTH - 1){1'b0}}};

    // Stage 1 registers
    logic signed [A_WIDTH-1:0] a_s1;
    logic signed [B_WIDTH-1:0] b_s1;
    logic                      v_s1;
    logic                      ae_s1;
    logic                      ac_s1;

    // Stage 2 registers
    logic signed [PROD_W-1:0]  prod_s2;
    logic                      v_s2;
    logic                      ae_s2;
    logic                      ac_s2;

    // Stage 3 registers
    logic signed [ACC_W-1:0]   acc;
    logic                      v_s3;

    // Stage 4 combinational scaling
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [EXT_W-1:0]   acc_x;
    logic signed [EXT_W-1:0]   rounded;
    logic signed [EXT_W-1:0]   shifted;
    logic        [P_WIDTH-1:0] s4_d;
    logic                      s4_sat;

    // Stage 4 and trailing delay registers; index DLY_N-1 drives the ports
    logic [P_WIDTH-1:0] d_pipe   [DLY_N];
    logic               sat_pipe [DLY_N];
    logic               v_pipe   [DLY_N];

    // Stage 1: capture operands and sample qualifiers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1  <= '0;
            b_s1  <= '0;
            v_s1  <= 1'b0;
            ae_s1 <= 1'b0;
            ac_s1 <= 1'b0;
        end else if (ce) begin
            a_s1  <= din0;
            b_s1  <= din1;
            v_s1  <= din_valid;
            ae_s1 <= acc_en;
            ac_s1 <= acc_clr;
        end
    end

    // Stage 2: exact signed product
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_s2 <= '0;
            v_s2    <= 1'b0;
            ae_s2   <= 1'b0;
            ac_s2   <= 1'b0;
        end else if (ce) begin
            prod_s2 <= a_s1 * b_s1;
            v_s2    <= v_s1;
            ae_s2   <= ae_s1;
            ac_s2   <= ac_s1;
        end
    end

    assign prod_ext = ACC_W'(prod_s2);

    // Stage 3: accumulator; a single register so back-to-back adds see the
    // previous sum without any forwarding
    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            v_s3 <= 1'b0;
        end else if (ce) begin
            v_s3 <= v_s2;
            if (v_s2) begin
                if (ae_s2 && !ac_s2) begin
                    acc <= acc + prod_ext;
                end else begin
                    acc <= prod_ext;
                end
            end
        end
    end

    assign acc_x   = EXT_W'(acc);
    assign rounded = acc_x + RND;
    assign shifted = rounded >>> FRAC_SHIFT;

    // Stage 4 datapath: clip or wrap the scaled accumulator to P_WIDTH
    always_comb begin
        s4_d   = shifted[P_WIDTH-1:0];
        s4_sat = 1'b0;
        if (SAT_EN != 0) begin
            if (shifted > P_MAX) begin
                s4_d   = P_MAX[P_WIDTH-1:0];
                s4_sat = 1'b1;
            end else if (shifted < P_MIN) begin
                s4_d   = P_MIN[P_WIDTH-1:0];
                s4_sat = 1'b1;
            end
        end
    end

    // Stage 4 register plus stages 5..NUM_STAGE as a plain shift line
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DLY_N; i++) begin
                d_pipe[i]   <= '0;
                sat_pipe[i] <= 1'b0;
                v_pipe[i]   <= 1'b0;
            end
        end else if (ce) begin
            d_pipe[0]   <= s4_d;
            sat_pipe[0] <= s4_sat;
            v_pipe[0]   <= v_s3;
            for (int i = 1; i < DLY_N; i++) begin
                d_pipe[i]   <= d_pipe[i-1];
                sat_pipe[i] <= sat_pipe[i-1];
                v_pipe[i]   <= v_pipe[i-1];
            end
        end
    end

    assign dout       = d_pipe[DLY_N-1];
    assign dout_sat   = sat_pipe[DLY_N-1];
    assign dout_valid = v_pipe[DLY_N-1];

endmodule

// File: tb/tb_bgd_mac_pipe.sv
// tb_bgd_mac_pipe: four differently configured bgd_mac_pipe instances share
// one stimulus stream; each has its own expected-result queue filled from
// an arithmetic reference model and drained by a single output monitor.
module tb_bgd_mac_pipe;

    localparam int NI = 4;
    // Instance configuration table (must match the instantiations below)
    localparam int FS [NI] = '{0, 0, 14, 14};
    localparam int RE [NI] = '{0, 0, 1, 0};
    localparam int SE [NI] = '{0, 1, 1, 1};
    localparam int NS [NI] = '{4, 6, 4, 5};

    logic               clk;
    logic               reset;
    logic               ce;
    logic               din_valid;
    logic signed [14:0] din0;
    logic signed [14:0] din1;
    logic               acc_en;
    logic               acc_clr;

    logic [14:0] dout_a [NI];
    logic        dv_a   [NI];
    logic        ds_a   [NI];

    // Scoreboard entry: [47:16] ce-edge index of appearance, [15] sat, [14:0] dout
    logic [47:0] exp_q [NI][$];

    int     n_chk  = 0;
    int     n_fail = 0;
    int     ce_cnt = 0;
    longint acc_m  = 0;
    logic   last_rst = 1'b1;
    logic   last_ce  = 1'b0;
    logic   end_chk  = 1'b0;
    logic [14:0] prev_d [NI];
    logic        prev_v [NI];
    logic        prev_s [NI];

    bgd_mac_pipe #(.FRAC_SHIFT(0), .ROUND_EN(0), .SAT_EN(0), .NUM_STAGE(4)) u_def (
        .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .dout_valid(dv_a[0]), .dout(dout_a[0]), .dout_sat(ds_a[0]));
    bgd_mac_pipe #(.FRAC_SHIFT(0), .ROUND_EN(0), .SAT_EN(1), .NUM_STAGE(6)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .dout_valid(dv_a[1]), .dout(dout_a[1]), .dout_sat(ds_a[1]));
    bgd_mac_pipe #(.FRAC_SHIFT(14), .ROUND_EN(1), .SAT_EN(1), .NUM_STAGE(4)) u_rnd (
        .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .dout_valid(dv_a[2]), .dout(dout_a[2]), .dout_sat(ds_a[2]));
    bgd_mac_pipe #(.FRAC_SHIFT(14), .ROUND_EN(0), .SAT_EN(1), .NUM_STAGE(5)) u_trn (
        .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .dout_valid(dv_a[3]), .dout(dout_a[3]), .dout_sat(ds_a[3]));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Accumulator is 34 bits (15+15+4) in every instance: wrap a longint to it.
    function automatic longint wrap_acc(input longint x);
        return (x <<< 30) >>> 30;
    endfunction

    // Scale, round, then saturate or wrap to a 15-bit signed result.
    function automatic logic [15:0] model_out(input longint acc, input int fs,
                                              input int re, input int se);
        longint v;
        logic   s;
        v = acc;
        if (re != 0 && fs > 0) v = v + (longint'(1) <<< (fs - 1));
        v = v >>> fs;
        s = 1'b0;
        if (se != 0) begin
            if (v > 16383) begin
                v = 16383;
                s = 1'b1;
            end else if (v < -16384) begin
                v = -16384;
                s = 1'b1;
            end
        end
        return {s, v[14:0]};
    endfunction

    // Stimulus side of the scoreboard: every accepted valid sample pushes
    // its expected result and the ce-edge on which it must appear.
    always @(posedge clk) begin
        longint      prod;
        logic [15:0] r;
        last_rst = reset;
        last_ce  = ce;
        if (reset) begin
            acc_m = 0;
            for (int g = 0; g < NI; g++) exp_q[g].delete();
        end else if (ce) begin
            ce_cnt++;
            if (din_valid) begin
                prod = longint'(din0) * longint'(din1);
                if (acc_en && !acc_clr) acc_m = wrap_acc(acc_m + prod);
                else                    acc_m = prod;
                for (int g = 0; g < NI; g++) begin
                    r = model_out(acc_m, FS[g], RE[g], SE[g]);
                    exp_q[g].push_back({32'(ce_cnt + NS[g] - 1), r});
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [47:0] e;
        for (int g = 0; g < NI; g++) begin
            if (last_rst) begin
                n_chk++;
                if (dout_a[g] !== 15'd0 || dv_a[g] !== 1'b0 || ds_a[g] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_out[%0d]: got dout=%0d valid=%b sat=%b, want 0/0/0",
                             g, $signed(dout_a[g]), dv_a[g], ds_a[g]);
                end
            end else if (!last_ce) begin
                n_chk++;
                if (dout_a[g] !== prev_d[g] || dv_a[g] !== prev_v[g] || ds_a[g] !== prev_s[g]) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d]: got dout=%0d valid=%b sat=%b, want %0d/%b/%b",
                             g, $signed(dout_a[g]), dv_a[g], ds_a[g],
                             $signed(prev_d[g]), prev_v[g], prev_s[g]);
                end
            end else if (exp_q[g].size() > 0 && exp_q[g][0][47:16] == ce_cnt) begin
                e = exp_q[g].pop_front();
                n_chk++;
                if (dv_a[g] !== 1'b1 || dout_a[g] !== e[14:0] || ds_a[g] !== e[15]) begin
                    n_fail++;
                    $display("FAIL result[%0d] edge %0d: got dout=%0d valid=%b sat=%b, want %0d/1/%b",
                             g, ce_cnt, $signed(dout_a[g]), dv_a[g], ds_a[g],
                             $signed(e[14:0]), e[15]);
                end
            end else begin
                n_chk++;
                if (dv_a[g] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL spurious_valid[%0d] edge %0d: got valid=%b dout=%0d, want valid=0",
                             g, ce_cnt, dv_a[g], $signed(dout_a[g]));
                end
            end
            prev_d[g] = dout_a[g];
            prev_v[g] = dv_a[g];
            prev_s[g] = ds_a[g];
        end
        if (end_chk) begin
            for (int g = 0; g < NI; g++) begin
                n_chk++;
                if (exp_q[g].size() != 0) begin
                    n_fail++;
                    $display("FAIL lost_results[%0d]: got %0d still pending, want 0",
                             g, exp_q[g].size());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int a, input int b, input logic v, input logic ae, input logic ac);
        @(negedge clk);
        reset     = 1'b0;
        ce        = 1'b1;
        din_valid = v;
        din0      = a[14:0];
        din1      = b[14:0];
        acc_en    = ae;
        acc_clr   = ac;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)),
                         1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // ce low with a valid-looking garbage sample: nothing may be accepted
    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk);
            reset     = 1'b0;
            ce        = 1'b0;
            din_valid = 1'b1;
            din0      = 15'($urandom_range(0, 32767));
            din1      = 15'($urandom_range(0, 32767));
            acc_en    = 1'($urandom_range(0, 1));
            acc_clr   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pulse_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            reset     = 1'b1;
            ce        = 1'($urandom_range(0, 1));
            din_valid = 1'b1;
        end
    endtask

    function automatic int rand_op();
        case ($urandom_range(0, 7))
            0:       return -16384;
            1:       return 16383;
            default: return int'($urandom_range(0, 32767)) - 16384;
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        reset     = 1'b1;
        ce        = 1'b1;
        din_valid = 1'b0;
        din0      = '0;
        din1      = '0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        repeat (3) @(negedge clk);

        // plain multiplies: basic, back-to-back, wrap/saturate, scaling corners
        drive(100, -50, 1, 0, 0);
        drive(7, 3, 1, 0, 0);
        drive(-2, -2, 1, 0, 0);
        drive(200, 200, 1, 0, 0);
        drive(-200, 200, 1, 0, 0);
        drive(8192, 8192, 1, 0, 0);
        drive(3, 2731, 1, 0, 0);
        drive(-16384, -16384, 1, 0, 0);
        idle(8);

        // accumulate chain, then the same chain with a bubble before the third add
        drive(10, 10, 1, 1, 1);
        drive(20, 3, 1, 1, 0);
        drive(-5, 4, 1, 1, 0);
        drive(2, 2, 1, 0, 0);
        drive(10, 10, 1, 1, 1);
        drive(20, 3, 1, 1, 0);
        idle(1);
        drive(-5, 4, 1, 1, 0);
        idle(8);

        // ce stall with a sample in flight
        drive(9, 9, 1, 0, 0);
        idle(1);
        stall(3);
        idle(8);

        // reset with three samples in flight, then accumulate from zero
        drive(11, 12, 1, 1, 0);
        drive(13, 14, 1, 1, 0);
        drive(15, 16, 1, 1, 0);
        pulse_reset(1);
        drive(5, 5, 1, 1, 0);
        drive(6, 6, 1, 1, 0);
        idle(8);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)       pulse_reset(1);
            else if (r < 12) stall(1);
            else drive(rand_op(), rand_op(), 1'($urandom_range(0, 99) < 80),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 20));
        end
        idle(10);

        @(posedge clk);
        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
